obi_fabric_regbank: RTL and testbench
=====================================

Name: obi_fabric_regbank

Overview:
- OBI subordinate implemented in fabric user logic, directly downstream of the tile's OBI peripheral pass-through primitive.
- Consumes the request channel (REQ/WE/BE/ADDR/WDATA) and produces the response channel (GNT/RVALID/RDATA).
- Terminates accesses into a byte-writable register bank, a read-only status word and an error counter.
- Grant wait states and response latency are configurable, so the external manager can be exercised under realistic timing.

Parameters:
- NUM_REGS, 8, number of 32-bit read/write registers; legal range 1..64.
- GNT_WAIT, 0, cycles REQ must be held before GNT asserts; legal range 0..15.
- RESP_LATENCY, 1, cycles from accepting edge to RVALID; legal range 1..4.

Ports:
- CLK  input  1  fabric clock.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  1  OBI request.
- WE  input  1  1 = write, 0 = read.
- BE  input  4  byte enables; BE[i] covers WDATA[8i+7:8i].
- ADDR  input  24  byte address; ADDR[1:0] ignored.
- WDATA  input  32  write data.
- GNT  output  1  OBI grant.
- RVALID  output  1  response valid, one-cycle pulse per transaction.
- RDATA  output  32  read data, valid only while RVALID=1.
- STATUS_IN  input  32  user status word, read-only.
- REGS_OUT  output  NUM_REGS*32  flat register bank; reg k occupies [32k+31:32k].

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values: GNT=0, RVALID=0, RDATA=0, all registers 0, error counter 0, wait counter 0, response pipeline empty.
- Reset overrides REQ: GNT is forced 0 while RESET=1.
- Reset mid-operation: responses still in the pipeline are dropped; no RVALID is emitted for them.
- Accept: a transaction is accepted on any rising edge where REQ=1 and GNT=1.
- Grant generation:
  - GNT = REQ and (wait_cnt == GNT_WAIT). This is combinational from REQ, so GNT_WAIT=0 grants in the same cycle.
  - wait_cnt is 4 bits. It increments each cycle REQ=1 and GNT=0.
  - wait_cnt clears to 0 on accept, or when REQ=0.
  - Back-to-back requests each re-incur GNT_WAIT cycles.
- Decode: word index idx = ADDR[23:2].
  - idx < NUM_REGS: register idx.
  - idx == NUM_REGS: STATUS_IN.
  - idx == NUM_REGS+1: ERRCNT.
  - All other idx: unmapped.
- Writes:
  - Committed at the accept edge; byte lanes with BE[i]=1 update, other lanes hold.
  - BE=0 writes change nothing but still produce a response.
  - Writes to STATUS are ignored.
  - A write to ERRCNT with any BE bit set clears it to 0.
- Reads:
  - Data is sampled at the accept edge.
  - ERRCNT reads as {24'h0, cnt}.
  - Unmapped reads return 32'h0.
  - Read-after-write: a read accepted on the edge after a write sees the new value.
- Error counter: 8-bit, saturates at 8'hFF, increments on every accepted unmapped access (read or write).
- Response:
  - RESP_LATENCY-deep shift pipeline carrying {valid, data}.
  - RVALID=1 exactly RESP_LATENCY cycles after the accept edge.
  - RDATA = read data for reads, 32'h0 for writes. RDATA returns to 0 when RVALID=0.
  - At most one accept per cycle, so there are no pipeline collisions.
  - There is no rready: responses cannot be back-pressured.
  - Responses are strictly in order; with RESP_LATENCY=R, up to R transactions can be outstanding.
- REGS_OUT is registered and updates the cycle after the accept edge.

Test Plan:
- Reset, then GNT_WAIT=0, RESP_LATENCY=1: write reg 2 with WDATA=32'hCAFE_F00D, BE=4'hF, then read ADDR=24'h000008 → GNT high in the same cycle as REQ; RVALID one cycle after each accept; read RDATA=32'hCAFE_F00D; REGS_OUT[95:64]=32'hCAFE_F00D.
- Partial write: reg 0 = 32'h1122_3344, then write 32'hAABB_CCDD with BE=4'b0101 → reg 0 reads 32'h11BB_33DD.
- GNT_WAIT=3: hold REQ → GNT asserts on the 4th REQ cycle. Back-to-back reads with REQ held high → each is granted after 3 wait cycles; RVALID count equals accept count.
- RESP_LATENCY=3, three consecutive reads of reg 0, 1, 2 → three RVALID pulses on consecutive cycles starting 3 cycles after the first accept, data in issue order.
- NUM_REGS=8: read ADDR=24'h000020 → STATUS_IN. Write 32'hFFFF_FFFF there → STATUS_IN is unchanged. Two unmapped accesses at 24'h000100 → RDATA=0 on the read, and ERRCNT reads 2. Write ERRCNT with BE=4'h1 → ERRCNT reads 0. 300 unmapped accesses → ERRCNT reads 8'hFF.
- RESET asserted with 2 responses in flight (RESP_LATENCY=4) → no RVALID afterwards, GNT=0 during reset, all REGS_OUT=0 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/obi_fabric_regbank.sv
// OBI subordinate terminating a byte-writable register bank, a read-only status word
// and a saturating error counter, with configurable grant wait states and response latency.
module obi_fabric_regbank #(
  parameter int NUM_REGS     = 8,
  parameter int GNT_WAIT     = 0,
  parameter int RESP_LATENCY = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     REQ,
  input  logic                     WE,
  input  logic [3:0]               BE,
  input  logic [23:0]              ADDR,
  input  logic [31:0]              WDATA,
  output logic                     GNT,
  output logic                     RVALID,
  output logic [31:0]              RDATA,
  input  logic [31:0]              STATUS_IN,
  output logic [NUM_REGS*32-1:0]   REGS_OUT
);

  localparam logic [21:0] IDX_STAT = 22'(NUM_REGS);
  localparam logic [21:0] IDX_ERR  = 22'(NUM_REGS + 1);
  localparam logic [3:0]  WAIT_TGT = 4'(GNT_WAIT);

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
  } rsp_t;

  rsp_t [RESP_LATENCY:1]        pipe_q, pipe_d;
  logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
  logic [3:0]                   wait_cnt_q, wait_cnt_d;
  logic [7:0]                   err_cnt_q, err_cnt_d;

  logic [21:0] idx;
  logic        hit_reg, hit_stat, hit_err, hit_none, accept;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign unused_addr = ^ADDR[1:0];

  always_comb begin
    // Grant is combinational from REQ; reset masks it so nothing is accepted while held.
    GNT        = REQ && !RESET && (wait_cnt_q == WAIT_TGT);
    accept     = GNT;
    wait_cnt_d = (accept || !REQ) ? 4'd0 : wait_cnt_q + 4'd1;

    idx      = ADDR[23:2];
    hit_reg  = idx < IDX_STAT;
    hit_stat = idx == IDX_STAT;
    hit_err  = idx == IDX_ERR;
    hit_none = !hit_reg && !hit_stat && !hit_err;

    rd_data = '0;
    regs_d  = regs_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hit_reg && idx == 22'(k)) begin
        rd_data = regs_q[k];
        if (accept && WE)
          for (int b = 0; b < 4; b++)
            if (BE[b]) regs_d[k][8*b +: 8] = WDATA[8*b +: 8];
      end
    end
    if (hit_stat) rd_data = STATUS_IN;
    if (hit_err)  rd_data = {24'h0, err_cnt_q};
    if (WE)       rd_data = '0;

    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (hit_err && WE && (|BE))             err_cnt_d = 8'h00;
      else if (hit_none && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Invalid slots carry zero data so RDATA idles at 0 without extra gating.
    pipe_d[1].vld  = accept;
    pipe_d[1].data = accept ? rd_data : 32'h0;
    for (int s = 2; s <= RESP_LATENCY; s++) pipe_d[s] = pipe_q[s-1];

    RVALID   = pipe_q[RESP_LATENCY].vld;
    RDATA    = pipe_q[RESP_LATENCY].data;
    REGS_OUT = regs_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe_q     <= '0;
      regs_q     <= '0;
      wait_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      pipe_q     <= pipe_d;
      regs_q     <= regs_d;
      wait_cnt_q <= wait_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_obi_fabric_regbank.sv
// Directed bench: four instances cover grant wait, response latency and reset-in-flight.
module tb_obi_fabric_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [4];
  logic        we;
  logic [3:0]  be;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] status;
  logic        gnt [4];
  logic        rvalid [4];
  logic [31:0] rdata [4];
  logic [255:0] ro [4];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rv_cnt [4] = '{default: 0};
  logic [31:0] log_d [$];
  int          log_c [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (rvalid[i]) begin
        rv_cnt[i]++;
        if (i == 2) begin
          log_d.push_back(rdata[2]);
          log_c.push_back(cyc);
        end
      end

  obi_fabric_regbank #(.NUM_REGS(8), .GNT_WAIT(0), .RESP_LATENCY(1)) u0 (
    .CLK(clk), .RESET(rst), .REQ(req[0]), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
    .GNT(gnt[0]), .RVALID(rvalid[0]), .RDATA(rdata[0]), .STATUS_IN(status), .REGS_OUT(ro[0]));
  obi_fabric_regbank #(.NUM_REGS(8), .GNT_WAIT(3), .RESP_LATENCY(1)) u1 (
    .CLK(clk), .RESET(rst), .REQ(req[1]), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
    .GNT(gnt[1]), .RVALID(rvalid[1]), .RDATA(rdata[1]), .STATUS_IN(status), .REGS_OUT(ro[1]));
  obi_fabric_regbank #(.NUM_REGS(8), .GNT_WAIT(0), .RESP_LATENCY(3)) u2 (
    .CLK(clk), .RESET(rst), .REQ(req[2]), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
    .GNT(gnt[2]), .RVALID(rvalid[2]), .RDATA(rdata[2]), .STATUS_IN(status), .REGS_OUT(ro[2]));
  obi_fabric_regbank #(.NUM_REGS(8), .GNT_WAIT(0), .RESP_LATENCY(4)) u3 (
    .CLK(clk), .RESET(rst), .REQ(req[3]), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
    .GNT(gnt[3]), .RVALID(rvalid[3]), .RDATA(rdata[3]), .STATUS_IN(status), .REGS_OUT(ro[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One serial transaction; returns grant wait cycles, response latency and RDATA.
  task automatic xfer(input int d, input logic we_i, input logic [3:0] be_i,
                      input logic [23:0] addr_i, input logic [31:0] wd_i,
                      output int waits, output int lat, output logic [31:0] rd);
    we = we_i; be = be_i; addr = addr_i; wdata = wd_i; req[d] = 1'b1;
    waits = 0;
    #1;
    while (!gnt[d] && waits < 50) begin
      @(negedge clk); #1; waits++;
    end
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
    lat = 1;
    #1;
    while (!rvalid[d] && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    rd = rdata[d];
  endtask

  int w, l, a, rv0;
  logic [31:0] d;
  logic [15:0] mask;
  logic [31:0] exp_d [4];

  initial begin
    rst = 1'b1; we = 1'b0; be = '0; addr = '0; wdata = '0; status = 32'h5A5A_1234;
    for (int i = 0; i < 4; i++) req[i] = 1'b0;
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt_forced", {31'b0, gnt[0]}, 0);
    req[0] = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_rvalid", {31'b0, rvalid[0]}, 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_regs", {31'b0, |ro[0]}, 0);
    chk("rst_gnt_idle", {31'b0, gnt[0]}, 0);

    // Full write then read back, zero wait, latency 1
    xfer(0, 1, 4'hF, 24'h000008, 32'hCAFE_F00D, w, l, d);
    chk("t1_wr_waits", w, 0);
    chk("t1_wr_lat", l, 1);
    chk("t1_wr_rdata", d, 0);
    xfer(0, 0, 4'hF, 24'h000008, 32'h0, w, l, d);
    chk("t1_rd_waits", w, 0);
    chk("t1_rd_lat", l, 1);
    chk("t1_rd_data", d, 32'hCAFE_F00D);
    chk("t1_regs_out", ro[0][95:64], 32'hCAFE_F00D);

    // Partial byte-lane write
    xfer(0, 1, 4'hF, 24'h000000, 32'h1122_3344, w, l, d);
    xfer(0, 1, 4'b0101, 24'h000000, 32'hAABB_CCDD, w, l, d);
    xfer(0, 0, 4'hF, 24'h000000, 32'h0, w, l, d);
    chk("t2_partial", d, 32'h11BB_33DD);
    xfer(0, 1, 4'h0, 24'h000000, 32'hFFFF_FFFF, w, l, d);
    chk("t2_be0_lat", l, 1);
    chk("t2_be0_hold", ro[0][31:0], 32'h11BB_33DD);

    // Status, unmapped and error counter
    xfer(0, 0, 4'hF, 24'h000020, 32'h0, w, l, d);
    chk("t5_status", d, 32'h5A5A_1234);
    xfer(0, 1, 4'hF, 24'h000020, 32'hFFFF_FFFF, w, l, d);
    xfer(0, 0, 4'hF, 24'h000020, 32'h0, w, l, d);
    chk("t5_status_ro", d, 32'h5A5A_1234);
    xfer(0, 0, 4'hF, 24'h000024, 32'h0, w, l, d);
    chk("t5_err_init", d, 0);
    xfer(0, 0, 4'hF, 24'h000100, 32'h0, w, l, d);
    chk("t5_unmapped_rd", d, 0);
    chk("t5_unmapped_lat", l, 1);
    xfer(0, 1, 4'hF, 24'h000100, 32'h1234_5678, w, l, d);
    xfer(0, 0, 4'hF, 24'h000024, 32'h0, w, l, d);
    chk("t5_err_two", d, 2);
    xfer(0, 1, 4'h1, 24'h000024, 32'h0, w, l, d);
    xfer(0, 0, 4'hF, 24'h000024, 32'h0, w, l, d);
    chk("t5_err_clear", d, 0);
    for (int i = 0; i < 300; i++) xfer(0, i[0], 4'hF, 24'h000100, 32'h0, w, l, d);
    xfer(0, 0, 4'hF, 24'h000024, 32'h0, w, l, d);
    chk("t5_err_sat", d, 32'h0000_00FF);
    chk("t5_regs_intact", ro[0][95:64], 32'hCAFE_F00D);

    // Grant wait of 3 cycles, then back-to-back with REQ held
    xfer(1, 0, 4'hF, 24'h000000, 32'h0, w, l, d);
    chk("t3_waits", w, 3);
    chk("t3_lat", l, 1);
    rv0 = rv_cnt[1];
    we = 1'b0; addr = 24'h0; req[1] = 1'b1;
    mask = '0;
    for (int i = 0; i < 16; i++) begin
      #1 mask[i] = gnt[1];
      @(negedge clk);
    end
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t3_gnt_pattern", {16'h0, mask}, 32'h0000_8888);
    chk("t3_rvalid_cnt", rv_cnt[1] - rv0, 4);

    // Latency 3: write then three consecutive reads, responses on consecutive cycles
    xfer(2, 1, 4'hF, 24'h000004, 32'h0000_1111, w, l, d);
    chk("t4_wr_lat", l, 3);
    xfer(2, 1, 4'hF, 24'h000008, 32'h0000_2222, w, l, d);
    log_d.delete(); log_c.delete();
    exp_d[0] = 32'h0; exp_d[1] = 32'hD00D_0000; exp_d[2] = 32'h0000_1111; exp_d[3] = 32'h0000_2222;
    a = 0;
    for (int j = 0; j < 4; j++) begin
      we = (j == 0); be = 4'hF; wdata = 32'hD00D_0000;
      addr = (j == 0) ? 24'h0 : 24'((j - 1) * 4);
      req[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (j == 0) a = cyc;
    end
    req[2] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t4_rsp_count", log_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_d.size()) begin
        chk($sformatf("t4_data%0d", i), log_d[i], exp_d[i]);
        chk($sformatf("t4_cyc%0d", i), log_c[i], a + 2 + i);
      end else begin
        chk($sformatf("t4_missing%0d", i), 0, 1);
      end
    end

    // Reset with two responses in flight at latency 4
    xfer(3, 1, 4'hF, 24'h000004, 32'h1234_5678, w, l, d);
    chk("t6_wr_lat", l, 4);
    chk("t6_pre_regs", ro[3][63:32], 32'h1234_5678);
    rv0 = rv_cnt[3];
    we = 1'b0; addr = 24'h000004; req[3] = 1'b1;
    @(posedge clk); @(negedge clk);
    addr = 24'h000008;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1 chk("t6_gnt_rst_a", {31'b0, gnt[3]}, 0);
    @(posedge clk); @(negedge clk);
    #1 chk("t6_gnt_rst_b", {31'b0, gnt[3]}, 0);
    rst = 1'b0; req[3] = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 chk("t6_regs_zero", {31'b0, |ro[3]}, 0);
    repeat (8) @(negedge clk);
    #1 chk("t6_no_rvalid", rv_cnt[3] - rv0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
